// File: rtl/pc_reg.sv
// Program-counter register for the instruction-fetch stage: holds the fetch
// address, drives the instruction-memory chip enable and exports pc + 4.
module pc_reg #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch,
    output logic              ce,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_4
);

    // The chip enable doubles as the fetch state: IDLE is the first cycle
    // out of reset, where the reset address is re-issued regardless of inputs.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq_addr;

    assign seq_addr = pc_q + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                pc_d = RESET_ADDR;
            end
            S_FETCH: begin
                // Branch wins over increment; a stall drops the branch request.
                if (pc_en) begin
                    pc_d = branch_en ? branch : seq_addr;
                end
            end
            default: begin
                pc_d = RESET_ADDR;
            end
        endcase
    end

    assign ce        = (state_q == S_FETCH);
    assign pc        = pc_q;
    assign pc_plus_4 = seq_addr;

endmodule

// File: tb/tb_pc_reg.sv
// Directed bench for pc_reg: stimulus pushes the expected post-edge state into
// a queue, and a monitor on the falling edge pops and compares.
module tb_pc_reg;

    localparam int unsigned ADDR_W = 32;

    typedef struct {
        logic              ce;
        logic [ADDR_W-1:0] pc;
        string             name;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              pc_en;
    logic              branch_en;
    logic [ADDR_W-1:0] branch;
    logic              ce;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus_4;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    pc_reg #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_en     (pc_en),
        .branch_en (branch_en),
        .branch    (branch),
        .ce        (ce),
        .pc        (pc),
        .pc_plus_4 (pc_plus_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one cycle of inputs and record the state expected after the edge.
    task automatic step(input logic r, input logic en, input logic ben,
                        input logic [ADDR_W-1:0] br,
                        input logic e_ce, input logic [ADDR_W-1:0] e_pc,
                        input string name);
        exp_t e;
        rst       = r;
        pc_en     = en;
        branch_en = ben;
        branch    = br;
        e.ce   = e_ce;
        e.pc   = e_pc;
        e.name = name;
        exp_q.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [ADDR_W-1:0] e_p4;
            e = exp_q.pop_front();
            popped++;
            e_p4 = e.pc + 32'd4;
            checks++;
            if (ce !== e.ce) begin
                errors++;
                $display("FAIL %s ce: got %b expected %b", e.name, ce, e.ce);
            end
            checks++;
            if (pc !== e.pc) begin
                errors++;
                $display("FAIL %s pc: got %h expected %h", e.name, pc, e.pc);
            end
            checks++;
            if (pc_plus_4 !== e_p4) begin
                errors++;
                $display("FAIL %s pc_plus_4: got %h expected %h", e.name, pc_plus_4, e_p4);
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1; pc_en = 1'b0; branch_en = 1'b0; branch = '0;

        for (int i = 0; i < 10; i++)
            step(1'b1, 1'($urandom), 1'($urandom), $urandom, 1'b0, 32'h0, "reset");

        // Release: reset address re-issued, then sequential fetch.
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0000, "release");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0004, "seq4");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0008, "seq8");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_000C, "seqC");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0010, "seq10");

        // Unaligned branch loaded verbatim.
        step(1'b0, 1'b1, 1'b1, 32'h3,   1'b1, 32'h0000_0003, "branch3");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0007, "seq7");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_000B, "seqB");

        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h0000_000B, "stall");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_000F, "resume");

        // Wrap-around.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, "branch_top");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0000, "wrap");

        // Reach 0x40 then reset mid-run with a branch pending.
        step(1'b0, 1'b1, 1'b1, 32'h3C,  1'b1, 32'h0000_003C, "branch3C");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0040, "seq40");
        step(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0000_0000, "midreset");
        step(1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h0000_0000, "release2");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0004, "reseq4");
        step(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0008, "reseq8");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        checks++;
        if (popped != pushed) begin
            errors++;
            $display("FAIL drain: popped %0d expected %0d", popped, pushed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
